lane_sweep_controller: RTL and testbench
========================================

# lane_sweep_controller

Parametrised sequencer for the lane-permutation datapath. Walks a DIM×DIM grid of LANE_W-bit lanes line by line. For every lane it fetches the lane from lane memory, reduces the lane's raw rotation offset modulo LANE_W by repeated subtraction, drives the rotator, and writes the result back. It supersedes the fixed 5×5 step controller: dimension, lane width and offset width are parameters, it keeps its own line and lane counters instead of taking an external count, and it adds a copy/rotate mode plus a hold (stall) input.

## Interface
- DIM, 5, grid dimension; lanes per line and number of lines.
- LANE_W, 64, lane width; must be a power of two, ≥ 2.
- OFF_W, 9, width of the raw offset; must be ≥ clog2(LANE_W).
- Derived constants:
  - AW = clog2(DIM*DIM)
  - IW = clog2(DIM)
  - RW = clog2(LANE_W)
- clk  in  1  single clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a sweep; sampled only in IDLE with hold=0.
- mode  in  1  0 = copy (rotation 0), 1 = rotate; latched when start is accepted.
- hold  in  1  stall; freezes the FSM, counters and remainder.
- offset_in  in  OFF_W  raw offset for the lane at mem_addr; combinational from the offset ROM.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- mem_addr  out  AW  line_idx*DIM + lane_idx.
- mem_rd  out  1  lane read strobe; read data is valid in the following cycle.
- mem_wr  out  1  lane write-back strobe to the same mem_addr.
- rot_en  out  1  rotator capture strobe.
- rot_amt  out  RW  left-rotate amount, valid while rot_en=1.
- line_idx  out  IW  current line.
- lane_idx  out  IW  current lane in the line.

## Operation
- States: IDLE, FETCH, REDUCE, APPLY, WRITE, DONE.
- IDLE:
  - Outputs 0, counters 0.
  - start & ~hold: latch mode, go to FETCH.
- FETCH:
  - mem_rd=1.
  - rem <= offset_in, zero-extended to OFF_W.
  - Next state: REDUCE if mode=1, else APPLY.
- REDUCE (rotate mode only):
  - If rem ≥ LANE_W: rem <= rem − LANE_W, stay in REDUCE.
  - Otherwise: go to APPLY.
  - rem is unsigned OFF_W; the subtraction never underflows because it is only taken when rem ≥ LANE_W.
- APPLY:
  - rot_en=1.
  - rot_amt = rem[RW-1:0] in rotate mode, 0 in copy mode.
- WRITE:
  - mem_wr=1.
  - Last lane of the line (lane_idx=DIM−1): lane_idx wraps to 0 and line_idx increments.
  - Last lane of the last line (both DIM−1): go to DONE with no counter change.
  - Otherwise: go to FETCH.
- DONE:
  - done=1, busy=1.
  - Go to IDLE next cycle; counters clear to 0.
- hold=1 in any state except IDLE:
  - State, counters and rem are frozen.
  - mem_rd, mem_wr, rot_en and done are forced to 0.
  - Asserting hold in DONE delays the done pulse until hold deasserts.
- start while busy is ignored; a mode change mid-sweep has no effect.
- Offset 0 and offsets that are exact multiples of LANE_W give rot_amt=0.
- The maximum offset, 2^OFF_W−1, takes (2^OFF_W−1)/LANE_W subtract cycles (integer division).

## Timing
- Reset: the next edge with rst=1 gives state IDLE, all counters and rem 0, and every output 0. This applies mid-sweep as well; no write is issued in the reset cycle.
- Lane cost:
  - Copy mode: 3 cycles.
  - Rotate mode: 4 + floor(offset/LANE_W) cycles.
- Sweep latency is measured from the start-accept edge to the cycle in which done is high, and equals the sum of the lane costs + 1:
  - Default parameters, copy mode: 76 cycles.
  - Default parameters, rotate mode with all offsets < 64: 101 cycles.
- Each hold cycle adds exactly 1 cycle to the latency.
- Every output is registered or decoded from state; there is no combinational path from offset_in to any output.
- A new start is accepted earliest in the IDLE cycle that follows DONE.

## Structure
- Shared package lane_ctrl_pkg:
  - state enum
  - MODE_COPY / MODE_ROT constants
  - clog2-derived width helpers
- One sub-module, lane_offset_reducer: holds the rem register, the compare-with-LANE_W, and the subtract. Ports: load, step, rem, ge_lane.
- The FSM, the line/lane counters and the address multiply-add stay in the top module.

## Test plan
- Reset mid-sweep: start in copy mode, assert rst during lane 7's WRITE → next cycle busy=0, mem_wr=0, line_idx=lane_idx=0; a fresh start restarts from address 0.
- Copy sweep, defaults: start pulse → mem_addr steps 0..24, each address read once then written once, done at cycle 76, rot_amt always 0.
- Rotate, offsets = address index: each lane takes 4 cycles, rot_amt = address; done at cycle 101.
- Large offsets: offset_in=300 at every lane, LANE_W=64 → 4 REDUCE subtract cycles per lane, rot_amt=44, lane cost 8, done at cycle 201.
- Hold: assert hold for 3 cycles during REDUCE and 2 cycles in DONE → no strobes while held, rem unchanged, done 5 cycles late; start during busy is ignored.
- Parametrisation: DIM=3, LANE_W=8, OFF_W=5, offset_in=31 → rot_amt=7, lane cost 7, done at cycle 64.

Source files
------------

// File: rtl/lane_sweep_controller_pkg.sv
`default_nettype none
//==============================================================================
// Package  : lane_ctrl_pkg
// Brief    : Shared types, mode constants and width helpers for the lane
//            sweep controller and its reducer.
// Revision : 1.0 - initial release
//==============================================================================
package lane_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_REDUCE = 3'd2,
        ST_APPLY  = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_ROT  = 1'b1;

    // clog2 that never returns 0, so degenerate sizes still give a 1-bit bus
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int addr_w(input int dim);
        return safe_clog2(dim * dim);
    endfunction

    function automatic int idx_w(input int dim);
        return safe_clog2(dim);
    endfunction

    function automatic int rot_w(input int lane_w);
        return safe_clog2(lane_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_sweep_controller_if.sv
`default_nettype none
//==============================================================================
// Interface : lane_sweep_controller_if
// Brief     : Control, offset-ROM and lane-memory/rotator strobes of the lane
//             sweep controller. master = sequencer client, slave = controller.
// Revision  : 1.0 - initial release
//==============================================================================
interface lane_sweep_controller_if #(
    parameter int DIM    = 5,
    parameter int LANE_W = 64,
    parameter int OFF_W  = 9
);
    localparam int AW = lane_ctrl_pkg::addr_w(DIM);
    localparam int IW = lane_ctrl_pkg::idx_w(DIM);
    localparam int RW = lane_ctrl_pkg::rot_w(LANE_W);

    logic             start;
    logic             mode;
    logic             hold;
    logic [OFF_W-1:0] offset_in;
    logic             busy;
    logic             done;
    logic [AW-1:0]    mem_addr;
    logic             mem_rd;
    logic             mem_wr;
    logic             rot_en;
    logic [RW-1:0]    rot_amt;
    logic [IW-1:0]    line_idx;
    logic [IW-1:0]    lane_idx;

    modport master (
        output start, mode, hold, offset_in,
        input  busy, done, mem_addr, mem_rd, mem_wr, rot_en, rot_amt,
               line_idx, lane_idx
    );

    modport slave (
        input  start, mode, hold, offset_in,
        output busy, done, mem_addr, mem_rd, mem_wr, rot_en, rot_amt,
               line_idx, lane_idx
    );

endinterface
`default_nettype wire

// File: rtl/lane_sweep_controller_reducer.sv
`default_nettype none
//==============================================================================
// Module   : lane_offset_reducer
// Brief    : Holds the per-lane remainder and reduces it modulo LANE_W by one
//            subtraction of LANE_W per step.
// Revision : 1.0 - initial release
//==============================================================================
module lane_offset_reducer #(
    parameter int LANE_W = 64,
    parameter int OFF_W  = 9
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic             step,
    input  wire logic [OFF_W-1:0] offset,
    output logic      [OFF_W-1:0] rem,
    output logic                  ge_lane
);
    // One extra bit so LANE_W == 2**OFF_W still compares correctly
    localparam logic [OFF_W:0]   c_LANE_CMP = (OFF_W + 1)'(LANE_W);
    localparam logic [OFF_W-1:0] c_LANE_SUB = OFF_W'(LANE_W);

    logic [OFF_W-1:0] r_rem;

    assign rem     = r_rem;
    assign ge_lane = ({1'b0, r_rem} >= c_LANE_CMP);

    // Remainder register: load wins over step; step only ever issued when ge_lane
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
        end else if (load) begin
            r_rem <= offset;
        end else if (step) begin
            r_rem <= r_rem - c_LANE_SUB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lane_sweep_controller.sv
`default_nettype none
//==============================================================================
// Module   : lane_sweep_controller
// Brief    : Walks a DIM x DIM grid of lanes; per lane fetches, reduces the
//            rotation offset modulo LANE_W, drives the rotator and writes back.
// Revision : 1.0 - initial release
//==============================================================================
module lane_sweep_controller
    import lane_ctrl_pkg::*;
#(
    parameter int DIM    = 5,
    parameter int LANE_W = 64,
    parameter int OFF_W  = 9
) (
    input wire logic                clk,
    input wire logic                rst,
    lane_sweep_controller_if.slave  bus
);
    localparam int AW = addr_w(DIM);
    localparam int IW = idx_w(DIM);
    localparam int RW = rot_w(LANE_W);

    localparam logic [IW-1:0] c_LAST_IDX = IW'(DIM - 1);
    localparam logic [AW-1:0] c_DIM_A    = AW'(DIM);

    state_t           r_state;
    logic             r_mode;
    logic [IW-1:0]    r_line;
    logic [IW-1:0]    r_lane;
    logic             r_busy;
    logic             r_rd;
    logic             r_wr;
    logic             r_rot;
    logic             r_done;

    logic [OFF_W-1:0] w_rem;
    logic             w_ge_lane;
    logic             w_frozen;
    logic             w_load;
    logic             w_step;
    logic             w_last_lane;
    logic             w_last_line;

    // hold stalls everything once a sweep is under way; in IDLE it only blocks start
    assign w_frozen    = bus.hold && (r_state != ST_IDLE);
    assign w_load      = (r_state == ST_FETCH)  && !bus.hold;
    assign w_step      = (r_state == ST_REDUCE) && w_ge_lane && !bus.hold;
    assign w_last_lane = (r_lane == c_LAST_IDX);
    assign w_last_line = (r_line == c_LAST_IDX);

    lane_offset_reducer #(
        .LANE_W (LANE_W),
        .OFF_W  (OFF_W)
    ) u_reducer (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .step    (w_step),
        .offset  (bus.offset_in),
        .rem     (w_rem),
        .ge_lane (w_ge_lane)
    );

    // Sequencer: state, counters and strobe flags for the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_COPY;
            r_line  <= '0;
            r_lane  <= '0;
            r_busy  <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_rot   <= 1'b0;
            r_done  <= 1'b0;
        end else if (!w_frozen) begin
            r_rd   <= 1'b0;
            r_wr   <= 1'b0;
            r_rot  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && !bus.hold) begin
                        r_mode  <= bus.mode;
                        r_state <= ST_FETCH;
                        r_busy  <= 1'b1;
                        r_rd    <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (r_mode == MODE_ROT) begin
                        r_state <= ST_REDUCE;
                    end else begin
                        r_state <= ST_APPLY;
                        r_rot   <= 1'b1;
                    end
                end
                ST_REDUCE: begin
                    if (!w_ge_lane) begin
                        r_state <= ST_APPLY;
                        r_rot   <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    r_state <= ST_WRITE;
                    r_wr    <= 1'b1;
                end
                ST_WRITE: begin
                    if (w_last_lane && w_last_line) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_FETCH;
                        r_rd    <= 1'b1;
                        if (w_last_lane) begin
                            r_lane <= '0;
                            r_line <= r_line + IW'(1);
                        end else begin
                            r_lane <= r_lane + IW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_line  <= '0;
                    r_lane  <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Strobes are suppressed while stalled and in the reset cycle itself
    assign bus.mem_rd   = r_rd   && !bus.hold && !rst;
    assign bus.mem_wr   = r_wr   && !bus.hold && !rst;
    assign bus.rot_en   = r_rot  && !bus.hold && !rst;
    assign bus.done     = r_done && !bus.hold && !rst;
    assign bus.busy     = r_busy;
    assign bus.line_idx = r_line;
    assign bus.lane_idx = r_lane;
    assign bus.mem_addr = (AW'(r_line) * c_DIM_A) + AW'(r_lane);
    assign bus.rot_amt  = ((r_state == ST_APPLY) && (r_mode == MODE_ROT)) ? RW'(w_rem) : '0;

endmodule
`default_nettype wire

// File: tb/tb_lane_sweep_controller.sv
`default_nettype none
//==============================================================================
// Module   : tb_lane_sweep_controller
// Brief    : Randomised bench for two controller instances (default and small
//            parameters) against a lane-cost / event-order reference model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_lane_sweep_controller;
    import lane_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lane_sweep_controller_if #(.DIM(5), .LANE_W(64), .OFF_W(9)) bus_a ();
    lane_sweep_controller_if #(.DIM(3), .LANE_W(8),  .OFF_W(5)) bus_b ();

    lane_sweep_controller #(.DIM(5), .LANE_W(64), .OFF_W(9)) u_dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    lane_sweep_controller #(.DIM(3), .LANE_W(8), .OFF_W(5)) u_dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    // Offset ROM shared by both instances (only one sweeps at a time)
    int rom [0:63];
    assign bus_a.offset_in = 9'(rom[bus_a.mem_addr]);
    assign bus_b.offset_in = 5'(rom[bus_b.mem_addr]);

    bit sel;
    logic s_rd, s_wr, s_rot, s_done, s_busy;
    int   s_addr, s_amt, s_line, s_lane;

    // View of whichever instance is under test
    always_comb begin
        if (sel) begin
            s_rd = bus_b.mem_rd; s_wr = bus_b.mem_wr; s_rot = bus_b.rot_en;
            s_done = bus_b.done; s_busy = bus_b.busy;
            s_addr = int'(bus_b.mem_addr); s_amt = int'(bus_b.rot_amt);
            s_line = int'(bus_b.line_idx); s_lane = int'(bus_b.lane_idx);
        end else begin
            s_rd = bus_a.mem_rd; s_wr = bus_a.mem_wr; s_rot = bus_a.rot_en;
            s_done = bus_a.done; s_busy = bus_a.busy;
            s_addr = int'(bus_a.mem_addr); s_amt = int'(bus_a.rot_amt);
            s_line = int'(bus_a.line_idx); s_lane = int'(bus_a.lane_idx);
        end
    end

    int n_total = 0;
    int n_bad   = 0;
    int last_lat;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input bit st, input bit md, input bit hd);
        if (sel) begin
            bus_b.start = st; bus_b.mode = md; bus_b.hold = hd;
        end else begin
            bus_a.start = st; bus_a.mode = md; bus_a.hold = hd;
        end
    endtask

    function automatic int lane_cost(input bit m, input int off, input int lw);
        return m ? (4 + off / lw) : 3;
    endfunction

    function automatic int dim_now();
        return sel ? 3 : 5;
    endfunction

    function automatic int lw_now();
        return sel ? 8 : 64;
    endfunction

    task automatic fill_rom(input int kind, input int val);
        int maxoff;
        maxoff = sel ? 31 : 511;
        for (int a = 0; a < 64; a++) begin
            case (kind)
                0:       rom[a] = $urandom_range(0, maxoff);
                1:       rom[a] = a;
                default: rom[a] = val;
            endcase
        end
    endtask

    // hmode: 0 no hold, 1 random hold, 2 hold 3 cycles early in lane 0 plus 2 in DONE
    task automatic run_sweep(input bit m, input int hmode, input bit noise, input string name);
        int dim, lw, n, sumcost, act, k, n_held, hold_done, viol;
        int nrd, nrot, nwr, lat, done_act, exp_fetch;
        int rd_addr [64], rd_act [64], rd_line [64], rd_lane [64];
        int rot_amt [64], wr_addr [64], wr_act [64];
        bit h, seen;
        dim = dim_now(); lw = lw_now(); n = dim * dim;
        sumcost = 0;
        for (int a = 0; a < n; a++) sumcost += lane_cost(m, rom[a], lw);
        act = 0; k = 0; n_held = 0; hold_done = 0; viol = 0;
        nrd = 0; nrot = 0; nwr = 0; lat = 0; done_act = 0; seen = 0;

        @(negedge clk);
        drive(1'b1, m, 1'b0);
        @(posedge clk); #1;
        while (!seen && k < 4000) begin
            k++;
            h = 1'b0;
            if (hmode == 1) h = (k >= 2) && ($urandom_range(0, 4) == 0);
            if (hmode == 2) begin
                if (k >= 3 && k <= 5) h = 1'b1;
                if (act == sumcost && hold_done < 2) begin
                    h = 1'b1;
                    hold_done++;
                end
            end
            drive(noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)), h);
            @(negedge clk);
            if (h) n_held++;
            else   act++;
            if (h && (s_rd || s_wr || s_rot || s_done)) viol++;
            if (k == 1) check({name, " busy_first"}, int'(s_busy), 1);
            if (s_rd && nrd < 64) begin
                rd_addr[nrd] = s_addr; rd_act[nrd] = act;
                rd_line[nrd] = s_line; rd_lane[nrd] = s_lane;
                nrd++;
            end
            if (s_rot && nrot < 64) begin
                rot_amt[nrot] = s_amt;
                nrot++;
            end
            if (s_wr && nwr < 64) begin
                wr_addr[nwr] = s_addr; wr_act[nwr] = act;
                nwr++;
            end
            if (s_done) begin
                seen = 1'b1; lat = k; done_act = act;
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0);
        #1;
        check({name, " done_seen"}, int'(seen), 1);
        check({name, " busy_after"}, int'(s_busy), 0);
        check({name, " done_pulse"}, int'(s_done), 0);
        check({name, " latency"}, lat, sumcost + 1 + n_held);
        check({name, " done_active"}, done_act, sumcost + 1);
        check({name, " held_strobes"}, viol, 0);
        check({name, " n_read"}, nrd, n);
        check({name, " n_rot"}, nrot, n);
        check({name, " n_write"}, nwr, n);
        exp_fetch = 1;
        for (int a = 0; a < n; a++) begin
            if (a < nrd) begin
                check({name, " rd_addr"}, rd_addr[a], a);
                check({name, " rd_cycle"}, rd_act[a], exp_fetch);
                check({name, " line_idx"}, rd_line[a], a / dim);
                check({name, " lane_idx"}, rd_lane[a], a % dim);
            end
            if (a < nrot) check({name, " rot_amt"}, rot_amt[a], m ? (rom[a] % lw) : 0);
            if (a < nwr) begin
                check({name, " wr_addr"}, wr_addr[a], a);
                check({name, " wr_cycle"}, wr_act[a], exp_fetch + lane_cost(m, rom[a], lw) - 1);
            end
            exp_fetch += lane_cost(m, rom[a], lw);
        end
        last_lat = lat;
    endtask

    task automatic check_idle_outputs(input string name);
        #1;
        check({name, " busy"}, int'(s_busy), 0);
        check({name, " done"}, int'(s_done), 0);
        check({name, " rd"}, int'(s_rd), 0);
        check({name, " wr"}, int'(s_wr), 0);
        check({name, " rot"}, int'(s_rot), 0);
        check({name, " addr"}, s_addr, 0);
        check({name, " amt"}, s_amt, 0);
        check({name, " line"}, s_line, 0);
        check({name, " lane"}, s_lane, 0);
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.mode = 1'b0; bus_a.hold = 1'b0;
        bus_b.start = 1'b0; bus_b.mode = 1'b0; bus_b.hold = 1'b0;
        sel = 1'b0;
        last_lat = 0;
        for (int a = 0; a < 64; a++) rom[a] = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sel = 1'b0; check_idle_outputs("reset_a");
        sel = 1'b1; check_idle_outputs("reset_b");
        sel = 1'b0;
        rst = 1'b0;

        // Default parameters, copy mode
        fill_rom(0, 0);
        run_sweep(MODE_COPY, 0, 1'b0, "copy");
        check("copy lat76", last_lat, 76);

        // Rotate with offset = address
        fill_rom(1, 0);
        run_sweep(MODE_ROT, 0, 1'b0, "rot_addr");
        check("rot_addr lat101", last_lat, 101);

        // Large offsets with holds in REDUCE and DONE, start noise while busy
        fill_rom(2, 300);
        run_sweep(MODE_ROT, 2, 1'b1, "rot300_hold");
        check("rot300 lat206", last_lat, 206);

        // Reset during lane 7's WRITE of a copy sweep
        fill_rom(0, 0);
        @(negedge clk);
        drive(1'b1, MODE_COPY, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 24; k++) @(posedge clk);
        @(negedge clk);
        check("midrst wr_before", int'(s_wr), 1);
        check("midrst addr_before", s_addr, 7);
        rst = 1'b1;
        #1;
        check("midrst wr_in_rst", int'(s_wr), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("midrst");
        run_sweep(MODE_COPY, 0, 1'b0, "after_rst");

        // Randomised sweeps on the default instance
        for (int i = 0; i < 4; i++) begin
            fill_rom(0, 0);
            run_sweep(1'($urandom_range(0, 1)), 1, 1'b1, "rand_a");
        end

        // Small parameter set
        sel = 1'b1;
        fill_rom(2, 31);
        run_sweep(MODE_ROT, 0, 1'b0, "small31");
        check("small31 lat64", last_lat, 64);
        for (int i = 0; i < 3; i++) begin
            fill_rom(0, 0);
            run_sweep(1'($urandom_range(0, 1)), 1, 1'b1, "rand_b");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
